// File: rtl/tach_rpm_meter.sv
// -----------------------------------------------------------------------------
// tach_rpm_meter
//
// Measures shaft speed from a single-channel tachometer pulse train. The raw
// pulse is synchronized into the clk domain and deglitched. Filtered rising
// edges are counted over a fixed gate window. Each completed window count is
// scaled to RPM and saturated to the output width.
//
// Ports:
//   clk          in   system clock, all state on the rising edge
//   reset        in   asynchronous active-low reset
//   en           in   measurement enable (0 holds counters idle, outputs hold)
//   tach_in      in   raw tach pulse, asynchronous to clk
//   rpm_measured out  RPM of the last completed window, saturated
//   rpm_valid    out  one-cycle pulse when rpm_measured updates
//   overflow     out  last window's edge count or RPM saturated
// -----------------------------------------------------------------------------
module tach_rpm_meter #(
    parameter int CLK_HZ         = 125_000_000,
    parameter int GATE_CYCLES    = 12_500_000,
    parameter int PULSES_PER_REV = 12,
    parameter int FILTER_CYCLES  = 4,
    parameter int RPM_RESOLUTION = 10,
    parameter int EDGE_CNT_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic                      tach_in,
    output logic [RPM_RESOLUTION-1:0] rpm_measured,
    output logic                      rpm_valid,
    output logic                      overflow
);

    // 60*CLK_HZ exceeds 32 bits at the default clock, so the scale is computed in 64 bits.
    localparam longint unsigned SCALE_NUM = 64'd60 * 64'(CLK_HZ);
    localparam longint unsigned SCALE_DEN = 64'(PULSES_PER_REV) * 64'(GATE_CYCLES);
    localparam longint unsigned SCALE_L   = SCALE_NUM / SCALE_DEN;
    localparam int              RPM_SCALE = int'(SCALE_L);

    localparam int GATE_W  = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam int FILT_W  = $clog2(FILTER_CYCLES + 1);
    localparam int SCALE_W = $clog2(RPM_SCALE + 1);
    // The product is wide enough for the full count times the scale and never narrower than the output.
    localparam int PROD_RAW_W = EDGE_CNT_WIDTH + SCALE_W;
    localparam int PROD_W     = (PROD_RAW_W > RPM_RESOLUTION) ? PROD_RAW_W : RPM_RESOLUTION;

    localparam logic [GATE_W-1:0]         GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [FILT_W-1:0]         FILT_LAST = FILT_W'(FILTER_CYCLES - 1);
    localparam logic [EDGE_CNT_WIDTH-1:0] CNT_MAX   = {EDGE_CNT_WIDTH{1'b1}};
    localparam logic [RPM_RESOLUTION-1:0] RPM_MAX   = {RPM_RESOLUTION{1'b1}};

    generate
        if ((SCALE_NUM % SCALE_DEN) != 64'd0) begin : g_scale_check
            $fatal(1, "tach_rpm_meter: 60*CLK_HZ not divisible by PULSES_PER_REV*GATE_CYCLES");
        end
        if (FILTER_CYCLES < 1) begin : g_filter_check
            $fatal(1, "tach_rpm_meter: FILTER_CYCLES must be at least 1");
        end
    endgenerate

    logic                      sync1_r;
    logic                      sync2_r;
    logic                      filt_r;
    logic                      filt_d_r;
    logic [FILT_W-1:0]         stab_cnt_r;
    logic [GATE_W-1:0]         gate_cnt_r;
    logic [EDGE_CNT_WIDTH-1:0] edge_cnt_r;
    logic                      sat_r;
    logic [EDGE_CNT_WIDTH-1:0] cnt_lat_r;
    logic                      sat_lat_r;
    logic                      cvt_valid_r;

    logic                      edge_s;
    logic                      tc_s;
    logic [EDGE_CNT_WIDTH-1:0] total_s;
    logic                      total_sat_s;
    logic [PROD_W-1:0]         prod_s;
    logic                      rpm_over_s;
    logic [RPM_RESOLUTION-1:0] rpm_sat_s;

    // Two-flop synchronizer for the asynchronous tach input.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= tach_in;
            sync2_r <= sync1_r;
        end
    end

    // Stability filter: accept a new level only after FILTER_CYCLES consecutive differing samples.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            filt_r     <= 1'b0;
            filt_d_r   <= 1'b0;
            stab_cnt_r <= '0;
        end else begin
            filt_d_r <= filt_r;
            if (sync2_r == filt_r) begin
                stab_cnt_r <= '0;
            end else if (stab_cnt_r == FILT_LAST) begin
                filt_r     <= sync2_r;
                stab_cnt_r <= '0;
            end else begin
                stab_cnt_r <= stab_cnt_r + FILT_W'(1);
            end
        end
    end

    // Edge detect, terminal-cycle decode and saturating window total including an edge on TC.
    always_comb begin
        edge_s      = filt_r & ~filt_d_r;
        tc_s        = en & (gate_cnt_r == GATE_LAST);
        total_s     = edge_cnt_r;
        total_sat_s = sat_r;
        if (edge_s) begin
            if (edge_cnt_r == CNT_MAX) begin
                total_s     = CNT_MAX;
                total_sat_s = 1'b1;
            end else begin
                total_s     = edge_cnt_r + EDGE_CNT_WIDTH'(1);
                total_sat_s = sat_r;
            end
        end else begin
            total_s     = edge_cnt_r;
            total_sat_s = sat_r;
        end
    end

    // Gate counter: free-running window timer, held at zero while disabled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gate_cnt_r <= '0;
        end else if (!en) begin
            gate_cnt_r <= '0;
        end else if (gate_cnt_r == GATE_LAST) begin
            gate_cnt_r <= '0;
        end else begin
            gate_cnt_r <= gate_cnt_r + GATE_W'(1);
        end
    end

    // Edge counter with saturation flag; window total is latched and the counter cleared on TC.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            edge_cnt_r  <= '0;
            sat_r       <= 1'b0;
            cnt_lat_r   <= '0;
            sat_lat_r   <= 1'b0;
            cvt_valid_r <= 1'b0;
        end else if (!en) begin
            edge_cnt_r  <= '0;
            sat_r       <= 1'b0;
            cvt_valid_r <= 1'b0;
        end else if (tc_s) begin
            cnt_lat_r   <= total_s;
            sat_lat_r   <= total_sat_s;
            edge_cnt_r  <= '0;
            sat_r       <= 1'b0;
            cvt_valid_r <= 1'b1;
        end else begin
            edge_cnt_r  <= total_s;
            sat_r       <= total_sat_s;
            cvt_valid_r <= 1'b0;
        end
    end

    // Count-to-RPM conversion with output saturation.
    always_comb begin
        prod_s     = PROD_W'(cnt_lat_r) * PROD_W'(RPM_SCALE);
        rpm_over_s = (prod_s > PROD_W'(RPM_MAX));
        if (rpm_over_s) begin
            rpm_sat_s = RPM_MAX;
        end else begin
            rpm_sat_s = prod_s[RPM_RESOLUTION-1:0];
        end
    end

    // Registered outputs: update one cycle after TC; a conversion is dropped if en is low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rpm_measured <= '0;
            rpm_valid    <= 1'b0;
            overflow     <= 1'b0;
        end else if (cvt_valid_r && en) begin
            rpm_measured <= rpm_sat_s;
            rpm_valid    <= 1'b1;
            overflow     <= sat_lat_r | rpm_over_s;
        end else begin
            rpm_measured <= rpm_measured;
            rpm_valid    <= 1'b0;
            overflow     <= overflow;
        end
    end

endmodule

// File: tb/tb_tach_rpm_meter.sv
// -----------------------------------------------------------------------------
// tb_tach_rpm_meter
//
// Directed self-checking bench for tach_rpm_meter with CLK_HZ=1000,
// GATE_CYCLES=100, PULSES_PER_REV=3, FILTER_CYCLES=2, giving 200 RPM per edge.
// Inputs are driven and outputs sampled on the falling clock edge. A rise of
// tach_in driven in interval k produces a filtered edge in interval k+4
// (2 synchronizer stages plus 2 filter cycles). Window start is the interval
// in which reset is released or en rises; rpm_valid appears 101 intervals later.
// -----------------------------------------------------------------------------
module tb_tach_rpm_meter;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       tach_in;
    logic [9:0] rpm_measured;
    logic       rpm_valid;
    logic       overflow;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int nvalid = 0;

    tach_rpm_meter #(
        .CLK_HZ         (1000),
        .GATE_CYCLES    (100),
        .PULSES_PER_REV (3),
        .FILTER_CYCLES  (2),
        .RPM_RESOLUTION (10),
        .EDGE_CNT_WIDTH (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .tach_in      (tach_in),
        .rpm_measured (rpm_measured),
        .rpm_valid    (rpm_valid),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    // Interval index: increments on every rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    // Count rpm_valid pulses, sampled away from the active edge.
    always @(negedge clk) if (rpm_valid === 1'b1) nvalid <= nvalid + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input int hi, input int lo);
        tach_in = 1'b1;
        step(hi);
        tach_in = 1'b0;
        step(lo);
    endtask

    // Advance until rpm_valid is seen; at = -1 when the bound expires.
    task automatic wait_valid(input int maxc, output int at);
        at = -1;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (rpm_valid === 1'b1) begin
                at = cyc;
                break;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int at;
        int prev;
        int nv0;

        reset   = 1'b0;
        en      = 1'b1;
        tach_in = 1'b0;
        step(3);
        check("reset_rpm",   32'(rpm_measured), 32'd0);
        check("reset_valid", 32'(rpm_valid),    32'd0);
        check("reset_ovf",   32'(overflow),     32'd0);

        // Nominal: 5 pulses of 10 high / 10 low in the first window.
        reset = 1'b1;
        base  = cyc;
        repeat (5) pulse(10, 10);
        wait_valid(20, at);
        check("nom_latency", 32'(at - base), 32'd101);
        check("nom_rpm",     32'(rpm_measured), 32'd1000);
        check("nom_ovf",     32'(overflow),     32'd0);
        step(1);
        check("nom_valid_one_cycle", 32'(rpm_valid), 32'd0);
        prev = at;
        repeat (5) pulse(10, 8);
        wait_valid(30, at);
        check("nom_period",  32'(at - prev), 32'd100);
        check("nom_rpm2",    32'(rpm_measured), 32'd1000);

        // Saturation: 6 pulses -> 1200 clipped to 1023, then 2 pulses -> 400.
        repeat (6) pulse(8, 7);
        wait_valid(30, at);
        check("sat_latency", 32'(at - base), 32'd301);
        check("sat_rpm",     32'(rpm_measured), 32'd1023);
        check("sat_ovf",     32'(overflow),     32'd1);
        repeat (2) pulse(10, 10);
        wait_valid(80, at);
        check("unsat_rpm",   32'(rpm_measured), 32'd400);
        check("unsat_ovf",   32'(overflow),     32'd0);

        // Glitch rejection: 1-clock highs between 3 valid pulses.
        repeat (3) begin
            pulse(1, 4);
            pulse(1, 4);
            pulse(10, 10);
        end
        wait_valid(30, at);
        check("glitch_latency", 32'(at - base), 32'd501);
        check("glitch_rpm",     32'(rpm_measured), 32'd600);

        // Window boundary: filtered edge on TC belongs to the ending window.
        step(94);
        tach_in = 1'b1;
        wait_valid(30, at);
        check("tc_edge_latency", 32'(at - base), 32'd601);
        check("tc_edge_rpm",     32'(rpm_measured), 32'd200);
        tach_in = 1'b0;
        wait_valid(120, at);
        check("tc_edge_next_rpm", 32'(rpm_measured), 32'd0);

        // Window boundary: edge one cycle after TC belongs to the next window.
        step(95);
        tach_in = 1'b1;
        wait_valid(30, at);
        check("post_tc_latency",  32'(at - base), 32'd801);
        check("post_tc_prev_rpm", 32'(rpm_measured), 32'd0);
        tach_in = 1'b0;
        wait_valid(120, at);
        check("post_tc_next_rpm", 32'(rpm_measured), 32'd200);

        // Enable control: drop en mid-window after 3 pulses, keep pulsing for 50 clocks.
        repeat (3) pulse(10, 10);
        nv0 = nvalid;
        en  = 1'b0;
        repeat (2) pulse(10, 10);
        step(10);
        check("en_off_no_valid", 32'(nvalid), 32'(nv0));
        check("en_off_hold_rpm", 32'(rpm_measured), 32'd200);
        check("en_off_valid_low", 32'(rpm_valid), 32'd0);
        en   = 1'b1;
        base = cyc;
        pulse(10, 10);
        wait_valid(120, at);
        check("en_on_latency", 32'(at - base), 32'd101);
        check("en_on_rpm",     32'(rpm_measured), 32'd200);
        check("en_on_ovf",     32'(overflow),     32'd0);

        // Reset asserted mid-window while a pulse is high: outputs clear at once.
        tach_in = 1'b1;
        step(5);
        reset = 1'b0;
        #1;
        check("async_rst_rpm",   32'(rpm_measured), 32'd0);
        check("async_rst_valid", 32'(rpm_valid),    32'd0);
        check("async_rst_ovf",   32'(overflow),     32'd0);
        tach_in = 1'b0;
        step(3);
        reset = 1'b1;
        base  = cyc;
        wait_valid(250, at);
        check("post_rst_latency", 32'(at - base), 32'd101);
        check("post_rst_rpm",     32'(rpm_measured), 32'd0);
        check("post_rst_ovf",     32'(overflow),     32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
